// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one PicoRV32 native-memory-interface slave between two masters:
// master 0 (CPU) and master 1 (loader/debug). A registered grant state
// machine (IDLE, GNT0, GNT1) selects the owner. The request fields reach
// the slave through a combinational mux on the state register. A watchdog
// aborts a granted transaction that the slave never acknowledges.
//
// Handshake (both master ports and the slave port): a requester raises
// valid and holds valid and every request field stable until it sees
// ready. Ready is a single-cycle completion pulse. The arbiter does not
// register requests.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break IDLE ties
// round-robin against the last master served. With the macro undefined,
// m1 wins every tie (fixed priority).
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a grant may wait for s_ready (0 = no watchdog)
//   ERR_RDATA       rdata returned to the master on an aborted transaction
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   m0_* / m1_*           master request (valid, instr, addr, wdata, wstrb)
//                         and response (ready, rdata)
//   s_*                   slave request (valid, instr, addr, wdata, wstrb)
//                         and response (ready, rdata)
//   grant                 one-hot owner, bit0 = m0, bit1 = m1, 00 when idle
//   timeout_err           one-cycle pulse when the watchdog aborts
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0
                                                             : 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        last;       // last master served: 0 = m0, 1 = m1

    logic        granted;
    logic        sel1;       // m1 owns the slave
    logic        gnt_valid;  // valid of the current owner
    logic        expired;    // watchdog fires this cycle
    logic        tie_pick1;  // winner of an IDLE tie is m1

    always_comb begin
        granted   = (state == GNT0) || (state == GNT1);
        sel1      = (state == GNT1);
        gnt_valid = sel1 ? m1_valid : m0_valid;
        // s_ready in the timeout cycle wins, so the watchdog only fires
        // when the slave is silent. A dropped valid is an abort, not a
        // timeout.
        expired   = TO_EN && granted && gnt_valid && !s_ready && (cnt == TO_LAST);
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_pick1 = ~last;
`else
    // Fixed priority: m1 wins. last is still maintained for observability.
    assign tie_pick1 = 1'b1;
    logic unused_last;
    assign unused_last = last;
`endif

    // Slave request mux. Everything is zero while idle so the slave sees a
    // clean bus between transactions.
    always_comb begin
        s_valid = granted && gnt_valid && !expired;
        s_instr = 1'b0;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_wstrb = 4'd0;
        if (state == GNT0) begin
            s_instr = m0_instr;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (state == GNT1) begin
            s_instr = m1_instr;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
    end

    // Response routing. Only the owner can see ready; rdata is shared and
    // replaced by ERR_RDATA for the owner when the watchdog fires.
    always_comb begin
        m0_ready    = (state == GNT0) && (s_ready || expired);
        m1_ready    = (state == GNT1) && (s_ready || expired);
        m0_rdata    = ((state == GNT0) && expired) ? ERR_RDATA : s_rdata;
        m1_rdata    = ((state == GNT1) && expired) ? ERR_RDATA : s_rdata;
        timeout_err = expired;
        grant       = {state == GNT1, state == GNT0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
            last  <= 1'b1;   // m0 wins the first round-robin tie
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    if (m0_valid && m1_valid)
                        state <= tie_pick1 ? GNT1 : GNT0;
                    else if (m0_valid)
                        state <= GNT0;
                    else if (m1_valid)
                        state <= GNT1;
                end
                GNT0, GNT1: begin
                    if (s_ready || expired) begin
                        // Completion always passes through IDLE so that
                        // s_valid drops between transactions.
                        state <= IDLE;
                        last  <= sel1;
                        cnt   <= 16'd0;
                    end else if (!gnt_valid) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a table of single-cycle vectors for the basic
// paths, then hand-written sequences for ties, contention, the watchdog,
// the ready/timeout collision and reset abort.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
        .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready),
        .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
        .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic        v0;
        logic        i0;
        logic [31:0] a0;
        logic [3:0]  ws0;
        logic [31:0] wd0;
        logic        v1;
        logic [31:0] a1;
        logic [3:0]  ws1;
        logic [31:0] wd1;
        logic        sr;
        logic [31:0] srd;
        logic [1:0]  e_g;
        logic        e_sv;
        logic [31:0] e_sa;
        logic [3:0]  e_ws;
        logic        e_r0;
        logic        e_r1;
        logic [31:0] e_rd;
        logic        e_to;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [1:0] first_g, second_g;
        logic       lastm, exp1;
        int         n0, n1, got0, got1;
        logic [31:0] exp_swd;

        reset = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;

        //            name        rst v0 i0 a0     ws0   wd0     v1 a1     ws1   wd1   sr srd           e_g   sv sa     ws    r0 r1 rd     to
        vecs[0]  = '{"reset",     1,  0, 0, 32'h0, 4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[1]  = '{"idle",      0,  0, 0, 32'h0, 4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[2]  = '{"wr_req",    0,  1, 0, 32'h80,4'hF, 32'h1E, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[3]  = '{"wr_gnt",    0,  1, 0, 32'h80,4'hF, 32'h1E, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b01, 1, 32'h80,4'hF, 0, 0, 32'h0, 0};
        vecs[4]  = '{"wr_done",   0,  1, 0, 32'h80,4'hF, 32'h1E, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0,        2'b01, 1, 32'h80,4'hF, 1, 0, 32'h0, 0};
        vecs[5]  = '{"wr_after",  0,  0, 0, 32'h0, 4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[6]  = '{"rd_req",    0,  0, 0, 32'h0, 4'h0, 32'h0,  1, 32'h80,4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[7]  = '{"rd_done",   0,  0, 0, 32'h0, 4'h0, 32'h0,  1, 32'h80,4'h0, 32'h0, 1, 32'h1E,       2'b10, 1, 32'h80,4'h0, 0, 1, 32'h1E,0};
        vecs[8]  = '{"rd_after",  0,  0, 0, 32'h0, 4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[9]  = '{"stray_rdy", 0,  0, 0, 32'h0, 4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 1, 32'hCAFEF00D, 2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[10] = '{"drop_req",  0,  1, 1, 32'h40,4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};
        vecs[11] = '{"drop_gnt",  0,  1, 1, 32'h40,4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b01, 1, 32'h40,4'h0, 0, 0, 32'h0, 0};
        vecs[12] = '{"drop_v",    0,  0, 1, 32'h40,4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b01, 0, 32'h40,4'h0, 0, 0, 32'h0, 0};
        vecs[13] = '{"drop_idle", 0,  0, 0, 32'h0, 4'h0, 32'h0,  0, 32'h0, 4'h0, 32'h0, 0, 32'h0,        2'b00, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0};

        // ---- table-driven vectors (one cycle each) ----
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            m0_valid = vecs[i].v0;  m0_instr = vecs[i].i0;  m0_addr = vecs[i].a0;
            m0_wstrb = vecs[i].ws0; m0_wdata = vecs[i].wd0;
            m1_valid = vecs[i].v1;  m1_instr = 1'b0;        m1_addr = vecs[i].a1;
            m1_wstrb = vecs[i].ws1; m1_wdata = vecs[i].wd1;
            s_ready  = vecs[i].sr;  s_rdata  = vecs[i].srd;
            #1;
            exp_swd = (vecs[i].e_g == 2'b01) ? vecs[i].wd0 :
                      (vecs[i].e_g == 2'b10) ? vecs[i].wd1 : 32'h0;
            chk({vecs[i].name, " grant"},   32'(grant),       32'(vecs[i].e_g));
            chk({vecs[i].name, " s_valid"}, 32'(s_valid),     32'(vecs[i].e_sv));
            chk({vecs[i].name, " s_addr"},  s_addr,           vecs[i].e_sa);
            chk({vecs[i].name, " s_wstrb"}, 32'(s_wstrb),     32'(vecs[i].e_ws));
            chk({vecs[i].name, " s_wdata"}, s_wdata,          exp_swd);
            chk({vecs[i].name, " s_instr"}, 32'(s_instr),
                32'((vecs[i].e_g == 2'b01) ? vecs[i].i0 : 1'b0));
            chk({vecs[i].name, " m0_ready"}, 32'(m0_ready),   32'(vecs[i].e_r0));
            chk({vecs[i].name, " m1_ready"}, 32'(m1_ready),   32'(vecs[i].e_r1));
            chk({vecs[i].name, " timeout"},  32'(timeout_err), 32'(vecs[i].e_to));
            if (vecs[i].e_r0) chk({vecs[i].name, " m0_rdata"}, m0_rdata, vecs[i].e_rd);
            if (vecs[i].e_r1) chk({vecs[i].name, " m1_rdata"}, m1_rdata, vecs[i].e_rd);
        end

        // ---- simultaneous requests from IDLE (last = m1 at this point) ----
        first_g  = RR ? 2'b01 : 2'b10;
        second_g = ~first_g;
        @(negedge clk);
        m0_valid = 1; m0_instr = 1; m0_addr = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1; m1_addr = 32'h4; m1_wstrb = 4'hF; m1_wdata = 32'h55;
        s_ready = 0;
        #1 chk("tie idle grant", 32'(grant), 32'h0);
        @(negedge clk);
        s_ready = 1; s_rdata = 32'h1111;
        #1;
        chk("tie first grant", 32'(grant), 32'(first_g));
        chk("tie first addr", s_addr, (first_g == 2'b01) ? 32'h0 : 32'h4);
        chk("tie first ready", 32'({m1_ready, m0_ready}), 32'(first_g));
        @(negedge clk);
        s_ready = 0;
        if (first_g == 2'b01) m0_valid = 0; else m1_valid = 0;
        #1 chk("tie gap grant", 32'(grant), 32'h0);
        @(negedge clk);
        s_ready = 1;
        #1;
        chk("tie second grant", 32'(grant), 32'(second_g));
        chk("tie second ready", 32'({m1_ready, m0_ready}), 32'(second_g));
        @(negedge clk);
        s_ready = 0; m0_valid = 0; m1_valid = 0;
        #1 chk("tie end grant", 32'(grant), 32'h0);

        // ---- continuous contention, 8 requests per master ----
        n0 = 8; n1 = 8; got0 = 0; got1 = 0;
        lastm = (second_g == 2'b10);
        m0_instr = 0; m0_wstrb = 4'hF; m1_wstrb = 4'hF;
        for (int it = 0; it < 40 && (n0 > 0 || n1 > 0); it++) begin
            @(negedge clk);
            m0_valid = (n0 > 0); m0_addr = 32'h100 + 32'(it);
            m1_valid = (n1 > 0); m1_addr = 32'h200 + 32'(it);
            s_ready = 0;
            #1 chk("cont idle grant", 32'(grant), 32'h0);
            exp1 = (n0 > 0 && n1 > 0) ? (RR ? ~lastm : 1'b1) : (n1 > 0);
            @(negedge clk);
            s_ready = 1;
            #1;
            chk("cont grant", 32'(grant), exp1 ? 32'h2 : 32'h1);
            if (m0_ready) got0++;
            if (m1_ready) got1++;
            if (exp1) n1--; else n0--;
            lastm = exp1;
        end
        @(negedge clk);
        s_ready = 0; m0_valid = 0; m1_valid = 0;
        #1;
        chk("cont m0 readies", 32'(got0), 32'd8);
        chk("cont m1 readies", 32'(got1), 32'd8);

        // ---- watchdog abort (pass 0) and ready/timeout collision (pass 1) ----
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            m0_valid = 1; m0_addr = 32'h300; m0_wstrb = 4'h0; m1_valid = 0;
            s_ready = 0; s_rdata = 32'h0;
            #1 chk("wd idle grant", 32'(grant), 32'h0);
            for (int k = 1; k < 16; k++) begin
                @(negedge clk);
                #1 chk("wd wait {grant,rdy,to}", 32'({grant, m0_ready, timeout_err}), 32'b0100);
            end
            @(negedge clk);
            if (pass == 1) begin s_ready = 1; s_rdata = 32'h12345678; end
            #1;
            chk("wd m0_ready", 32'(m0_ready), 32'h1);
            chk("wd m0_rdata", m0_rdata, (pass == 1) ? 32'h12345678 : 32'hDEADBEEF);
            chk("wd timeout_err", 32'(timeout_err), (pass == 1) ? 32'h0 : 32'h1);
            chk("wd s_valid", 32'(s_valid), (pass == 1) ? 32'h1 : 32'h0);
            @(negedge clk);
            s_ready = 0; m0_valid = 0;
            #1;
            chk("wd after grant", 32'(grant), 32'h0);
            chk("wd after timeout", 32'(timeout_err), 32'h0);
        end

        // ---- reset two cycles into a granted m1 transaction ----
        @(negedge clk);
        m1_valid = 1; m1_addr = 32'h400; m1_wstrb = 4'h0;
        #1 chk("rst idle grant", 32'(grant), 32'h0);
        @(negedge clk);
        #1 chk("rst gnt1 grant", 32'(grant), 32'h2);
        @(negedge clk);
        reset = 1;
        #1;
        chk("rst gnt2 grant", 32'(grant), 32'h2);
        chk("rst gnt2 ready", 32'({m1_ready, m0_ready}), 32'h0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst after grant", 32'(grant), 32'h0);
        chk("rst after s_valid", 32'(s_valid), 32'h0);
        chk("rst after ready", 32'({m1_ready, m0_ready}), 32'h0);
        @(negedge clk);
        m1_valid = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares one PicoRV32-native-memory-interface slave (the `bram_controller`) between the CPU (master 0) and a loader/debug master (master 1). It replaces the ad-hoc valid/addr/wdata/wstrb multiplexing at the BRAM port with a registered grant state machine, so the loader can write programs or read results while the CPU is live. It also includes a watchdog that terminates a transaction the slave never acknowledges.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles a granted transaction may wait for `s_ready` before being aborted. 0 disables the watchdog. Range 0..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: value returned on `mX_rdata` for an aborted transaction.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `m0_valid`, `m0_instr` in 1 each: CPU request and instruction-fetch flag.
- `m0_addr`, `m0_wdata` in 32 each: CPU address and write data.
- `m0_wstrb` in 4: CPU byte strobes; 0 means read.
- `m0_ready` out 1: CPU transaction complete, single-cycle pulse.
- `m0_rdata` out 32: read data for the CPU.
- `m1_*`: identical set of ports for the loader/debug master.
- `s_valid`, `s_instr` out 1 each: slave request and instruction flag.
- `s_addr`, `s_wdata` out 32 each: slave address and write data.
- `s_wstrb` out 4: slave byte strobes.
- `s_ready` in 1: slave completion pulse.
- `s_rdata` in 32: slave read data.
- `grant` out 2: one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.
- `timeout_err` out 1: one-cycle pulse when a transaction is aborted.

## Operation

- State register with three states: IDLE, GNT0, GNT1. There is also a 16-bit wait counter and a 1-bit `last` register recording the last master served.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one `mX_valid` high: go to GNTX.
  - Both high: choose per Configuration.
  - The wait counter clears.
- **GNTX**
  - `s_valid = mX_valid`. `s_instr`, `s_addr`, `s_wdata` and `s_wstrb` are taken from master X through a combinational mux on the state register.
  - `mX_ready = s_ready` and `mX_rdata = s_rdata`. The non-granted master's ready is held at 0; its rdata is don't-care (driven from `s_rdata`).
  - `s_ready` high: go to IDLE and set `last = X`.
  - Granted `mX_valid` dropped before `s_ready` (protocol abort, e.g. CPU reset): `s_valid` falls the same cycle and the state returns to IDLE. `last` is unchanged and there is no error.
  - Otherwise the counter increments.
  - Counter reaches `TIMEOUT_CYCLES - 1` with `s_ready` low and `TIMEOUT_CYCLES != 0`: that cycle drive `mX_ready = 1`, `mX_rdata = ERR_RDATA`, `timeout_err = 1`, `s_valid = 0`. Then go to IDLE and set `last = X`.
- `s_ready` and timeout in the same cycle: the ready wins, real data is returned and `timeout_err` stays low.
- `s_ready` while in IDLE (stray pulse): ignored. No master sees a ready.
- After each completed transaction there is always one IDLE cycle before the next grant. This guarantees `s_valid` drops between transactions, which the BRAM controller requires.

## Timing

- Reset values: state IDLE, `last = 1` (so m0 wins the first round-robin tie), counter 0.
  - Outputs at reset: `grant = 0`, `s_valid = 0`, `s_wstrb = 0`, `s_instr = 0`, `s_addr = 0`, `s_wdata = 0`, `m0_ready = m1_ready = 0`, `timeout_err = 0`.
- Reset asserted mid-transaction: next edge returns to IDLE. `s_valid` falls and no ready is issued to either master.
- Arbitration latency: `mX_valid` rises in cycle N (state IDLE) → `grant` and `s_valid` are high from cycle N+1.
- Completion: `s_ready` in cycle M → `mX_ready` in cycle M (combinational) → `grant = 0` in cycle M+1 → earliest next `s_valid` in cycle M+2.
- Minimum transaction spacing is therefore slave latency plus 2 cycles.
- Masters must hold `valid` and all request fields stable until their `ready`. Requests are not registered inside the arbiter.

## Configuration

- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, grant the master not equal to `last`. This gives strict alternation under continuous contention.
- Not defined: on a tie, m1 always wins (fixed priority). The loader can then starve the CPU, which is intended for program loading with the CPU running. `last` is still maintained but not used.

## Test plan

- **Single CPU write.** m0 writes 0x0000001E, wstrb 4'b1111, at address 0x80 → `s_valid` one cycle after `m0_valid`, with `grant = 01`. `m0_ready` pulses. A following m1 read of 0x80 returns 0x0000001E.
- **Simultaneous requests from IDLE.** m0 fetches from 0x00 while m1 writes to 0x04.
  - With the macro defined: m0 is served first after reset, then m1.
  - Without the macro: m1 is served first.
  - In both cases `grant` shows 00 between the two grants.
- **Continuous contention, 8 back-to-back requests per master, macro defined.** Grants alternate m0, m1, m0, and so on. Each master receives exactly 8 ready pulses.
- **Watchdog abort.** Slave model never asserts ready, `TIMEOUT_CYCLES = 16`. Grant in cycle N+1 → in cycle N+16 `m0_ready = 1`, `m0_rdata = 32'hDEADBEEF`, `timeout_err = 1`. `grant = 00` in cycle N+17.
- **Ready and timeout collide.** `s_ready` arrives in exactly the timeout cycle, carrying rdata 0x12345678 → `m0_rdata = 0x12345678` and `timeout_err = 0`.
- **Aborts.**
  - `reset` asserted two cycles into a granted m1 transaction → next cycle `grant = 00` and `s_valid = 0`, with no ready to either master.
  - m0 drops `valid` mid-grant → IDLE next cycle with no error.
